// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: counter state encodings and default table size for the branch predictor.
package branch_predictor_pkg;
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;
    localparam int DEF_ENTRIES = 64;
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch prediction, execute update, flush and statistics signals.
//   master = pipeline side, slave = predictor side.
interface branch_predictor_if;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        pred_resp_valid;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_pred_taken;
    logic        flush;
    logic        mispredict;
    logic        cnt_clr;
    logic [31:0] mispredict_count;
    modport master (
        output pred_req, pred_pc, upd_valid, upd_pc, upd_taken, upd_pred_taken, flush, cnt_clr,
        input  pred_resp_valid, pred_taken, mispredict, mispredict_count
    );
    modport slave (
        input  pred_req, pred_pc, upd_valid, upd_pc, upd_taken, upd_pred_taken, flush, cnt_clr,
        output pred_resp_valid, pred_taken, mispredict, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating direction counter.
//   cur: current state, taken: resolved outcome, nxt: next state.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_e cur,
    input  logic taken,
    output ctr_e nxt
);
    always_comb nxt = taken ? ((cur == ST)  ? ST  : ctr_e'(cur + 2'd1))
                            : ((cur == SNT) ? SNT : ctr_e'(cur - 2'd1));
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal predictor with a flop-based table of 2-bit counters.
//   clk, rst_n (async active-low); bus: slave side of branch_predictor_if
//   (prediction request/response, resolved update, flush, mispredict statistics).
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input logic               clk,
    input logic               rst_n,
    branch_predictor_if.slave bus
);
    logic [1:0]       tbl_q [ENTRIES];
    logic [1:0]       tbl_d [ENTRIES];
    logic [IDX_W-1:0] pred_idx, upd_idx;
    ctr_e             upd_next;
    logic             pred_fire;
    logic             pred_resp_valid_q, pred_resp_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic             mispredict_q, mispredict_d;
    logic [31:0]      mispredict_count_q, mispredict_count_d;
    logic             unused_pc_bits;

    assign pred_idx  = bus.pred_pc[IDX_W+1:2];
    assign upd_idx   = bus.upd_pc[IDX_W+1:2];
    assign pred_fire = bus.pred_req & ~bus.flush;
    assign unused_pc_bits = ^{bus.pred_pc[31:IDX_W+2], bus.pred_pc[1:0],
                              bus.upd_pc[31:IDX_W+2], bus.upd_pc[1:0]};

    sat_counter2 u_sat (.cur(ctr_e'(tbl_q[upd_idx])), .taken(bus.upd_taken), .nxt(upd_next));

    // Prediction reads tbl_q, so a same-edge update is seen only by later requests.
    always_comb begin
        tbl_d = tbl_q;
        if (bus.upd_valid) tbl_d[upd_idx] = upd_next;
        pred_resp_valid_d  = pred_fire;
        pred_taken_d       = pred_fire ? tbl_q[pred_idx][1] : pred_taken_q;
        mispredict_d       = bus.upd_valid & (bus.upd_taken ^ bus.upd_pred_taken);
        mispredict_count_d = bus.cnt_clr ? 32'd0
                           : (mispredict_d && mispredict_count_q != 32'hFFFF_FFFF) ? mispredict_count_q + 32'd1
                           : mispredict_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= WNT;
            pred_resp_valid_q  <= 1'b0;
            pred_taken_q       <= 1'b0;
            mispredict_q       <= 1'b0;
            mispredict_count_q <= 32'd0;
        end else begin
            tbl_q              <= tbl_d;
            pred_resp_valid_q  <= pred_resp_valid_d;
            pred_taken_q       <= pred_taken_d;
            mispredict_q       <= mispredict_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign bus.pred_resp_valid  = pred_resp_valid_q;
    assign bus.pred_taken       = pred_taken_q;
    assign bus.mispredict       = mispredict_q;
    assign bus.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and random checks of branch_predictor against a behavioural model.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if bus ();
    branch_predictor #(.ENTRIES(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          checks = 0;
    int          errors = 0;
    int          model [64];
    logic        e_valid, e_taken, e_mis;
    logic [31:0] e_cnt;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pred_resp_valid", 32'(bus.pred_resp_valid), 32'(e_valid));
        chk("pred_taken", 32'(bus.pred_taken), 32'(e_taken));
        chk("mispredict", 32'(bus.mispredict), 32'(e_mis));
        chk("mispredict_count", bus.mispredict_count, e_cnt);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model[i] = 1;
        e_valid = 0; e_taken = 0; e_mis = 0; e_cnt = 0;
    endtask

    task automatic idle();
        bus.pred_req = 0; bus.pred_pc = 0; bus.upd_valid = 0; bus.upd_pc = 0;
        bus.upd_taken = 0; bus.upd_pred_taken = 0; bus.flush = 0; bus.cnt_clr = 0;
    endtask

    // Predict the effect of the coming edge from the current inputs, then clock and compare.
    task automatic step();
        int k;
        e_valid = bus.pred_req && !bus.flush;
        if (e_valid) e_taken = model[idx_of(bus.pred_pc)] >= 2;
        if (bus.upd_valid) begin
            k = idx_of(bus.upd_pc);
            model[k] = bus.upd_taken ? (model[k] < 3 ? model[k] + 1 : 3) : (model[k] > 0 ? model[k] - 1 : 0);
        end
        e_mis = bus.upd_valid && (bus.upd_taken != bus.upd_pred_taken);
        e_cnt = bus.cnt_clr ? 0 : (e_mis && e_cnt != 32'hFFFF_FFFF) ? e_cnt + 1 : e_cnt;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic predict(logic [31:0] pc);
        idle(); bus.pred_req = 1; bus.pred_pc = pc; step();
    endtask

    task automatic update(logic [31:0] pc, logic t, logic pt);
        idle(); bus.upd_valid = 1; bus.upd_pc = pc; bus.upd_taken = t; bus.upd_pred_taken = pt; step();
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        check_all();
        rst_n = 1;
        predict(32'h40);
        chk("req033 taken", 32'(bus.pred_taken), 32'd0);
        update(32'h40, 1, 1);
        update(32'h40, 1, 1);
        predict(32'h40);
        chk("req034 taken", 32'(bus.pred_taken), 32'd1);
        predict(32'h140);
        chk("req034 alias", 32'(bus.pred_taken), 32'd1);
        for (int i = 0; i < 3; i++) update(32'h80, 0, 0);
        update(32'h80, 1, 0);
        predict(32'h80);
        chk("req035 taken", 32'(bus.pred_taken), 32'd0);
        idle();
        bus.pred_req = 1; bus.pred_pc = 32'hC0;
        bus.upd_valid = 1; bus.upd_pc = 32'hC0; bus.upd_taken = 1; bus.upd_pred_taken = 1;
        step();
        chk("req036 same edge", 32'(bus.pred_taken), 32'd0);
        predict(32'hC0);
        chk("req036 after", 32'(bus.pred_taken), 32'd1);
        idle(); bus.cnt_clr = 1; step();
        update(32'h10, 1, 0);
        chk("req037 count", bus.mispredict_count, 32'd1);
        idle(); step();
        chk("req037 drop", 32'(bus.mispredict), 32'd0);
        idle(); bus.upd_valid = 1; bus.upd_pc = 32'h10; bus.upd_taken = 1; bus.cnt_clr = 1; step();
        chk("req037 clr", bus.mispredict_count, 32'd0);
        idle(); bus.pred_req = 1; bus.pred_pc = 32'h40; bus.flush = 1; step();
        chk("req038 flush", 32'(bus.pred_resp_valid), 32'd0);
        for (int n = 0; n < 400; n++) begin
            bus.pred_req       = $urandom_range(0, 3) != 0;
            bus.pred_pc        = $urandom;
            bus.upd_valid      = $urandom_range(0, 2) != 0;
            bus.upd_pc         = {$urandom_range(0, 255), 4'($urandom_range(0, 15)), 2'b00};
            bus.upd_taken      = 1'($urandom);
            bus.upd_pred_taken = 1'($urandom);
            bus.flush          = $urandom_range(0, 7) == 0;
            bus.cnt_clr        = $urandom_range(0, 31) == 0;
            step();
        end
        update(32'h40, 1, 1);
        update(32'h40, 1, 1);
        idle();
        bus.pred_req = 1; bus.pred_pc = 32'h40; bus.upd_valid = 1; bus.upd_pc = 32'h40;
        bus.upd_taken = 1; bus.upd_pred_taken = 0;
        rst_n = 0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        idle();
        rst_n = 1;
        step();
        predict(32'h40);
        chk("reset entry WNT", 32'(bus.pred_taken), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
